// File: rtl/tjmono2_rx_fifo_arbiter.sv
// Round-robin read arbiter merging N_CH FWFT channel FIFOs
// into a single registered FWFT 32-bit output stream.
module tjmono2_rx_fifo_arbiter #(
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST,
  input  logic [N_CH-1:0]   CH_EN,
  input  logic [N_CH-1:0]   CH_EMPTY,
  input  logic [32*N_CH-1:0] CH_DATA,
  output logic [N_CH-1:0]   CH_READ,
  input  logic              OUT_READ,
  output logic              OUT_EMPTY,
  output logic [31:0]       OUT_DATA,
  output logic [N_CH-1:0]   GRANT,
  output logic [31:0]       WORD_CNT
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic            out_empty_q, out_empty_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [31:0]     word_cnt_q, word_cnt_d;

  logic [N_CH-1:0] req;
  logic            hit;
  logic [PW-1:0]   hit_idx;
  logic            g_empty;
  logic            g_en;
  logic [31:0]     g_data;
  logic [PW-1:0]   g_next;
  logic            can_load;
  logic            rd;
  logic            last;
  logic            leave;
  logic [N_CH-1:0] grant_oh;

  // State and datapath registers
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      burst_q     <= '0;
      out_empty_q <= 1'b1;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      burst_q     <= burst_d;
      out_empty_q <= out_empty_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Rotating search for the first requesting channel from ptr
  always_comb begin
    int j;
    j       = 0;
    req     = CH_EN & ~CH_EMPTY;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      j = (int'(ptr_q) + i) % N_CH;
      if (!hit && req[j]) begin
        hit     = 1'b1;
        hit_idx = PW'(j);
      end
    end
  end

  // Granted-channel view, read strobe and burst exit condition
  always_comb begin
    g_empty  = CH_EMPTY[gidx_q];
    g_en     = CH_EN[gidx_q];
    g_data   = CH_DATA[32*gidx_q +: 32];
    g_next   = (int'(gidx_q) == N_CH - 1) ? '0 : gidx_q + 1'b1;
    can_load = out_empty_q | OUT_READ;
    rd       = (state_q == S_GRANT) & can_load & ~g_empty & g_en;
    last     = rd && (burst_q == CW'(MAX_BURST - 1));
    leave    = (state_q == S_GRANT) && (last || g_empty || !g_en);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hit) state_d = S_GRANT;
      S_GRANT: if (leave) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer, burst counter, output buffer and word counter updates
  always_comb begin
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    burst_d     = burst_q;
    out_empty_d = out_empty_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    if (state_q == S_IDLE && hit) begin
      gidx_d  = hit_idx;
      burst_d = '0;
    end
    if (rd) begin
      burst_d     = burst_q + 1'b1;
      out_data_d  = g_data;
      out_empty_d = 1'b0;
      if (word_cnt_q != 32'hFFFF_FFFF)
        word_cnt_d = word_cnt_q + 32'd1;
    end else if (OUT_READ && !out_empty_q) begin
      out_empty_d = 1'b1;
    end
    if (leave) ptr_d = g_next;
  end

  // Output drive
  always_comb begin
    grant_oh  = N_CH'(1) << gidx_q;
    CH_READ   = rd ? grant_oh : '0;
    GRANT     = (state_q == S_GRANT) ? grant_oh : '0;
    OUT_EMPTY = out_empty_q;
    OUT_DATA  = out_data_q;
    WORD_CNT  = word_cnt_q;
  end

endmodule

// File: tb/tb_tjmono2_rx_fifo_arbiter.sv
// Randomized scoreboard bench for the RX FIFO arbiter.
// Channel FIFOs and the round-robin order are modelled with queues.
module tb_tjmono2_rx_fifo_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;

  typedef logic [31:0] wq_t[$];

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_en, ch_empty, ch_read, grant;
  logic [32*N-1:0] ch_data;
  logic            out_read, out_empty;
  logic [31:0]     out_data, word_cnt;

  always #5 clk = ~clk;

  tjmono2_rx_fifo_arbiter #(.N_CH(N), .MAX_BURST(MB)) dut (
    .BUS_CLK  (clk),
    .BUS_RST  (rst),
    .CH_EN    (ch_en),
    .CH_EMPTY (ch_empty),
    .CH_DATA  (ch_data),
    .CH_READ  (ch_read),
    .OUT_READ (out_read),
    .OUT_EMPTY(out_empty),
    .OUT_DATA (out_data),
    .GRANT    (grant),
    .WORD_CNT (word_cnt)
  );

  int          checks = 0;
  int          failures = 0;
  wq_t         ch_q[N];
  wq_t         exp_ch[N];
  logic [31:0] exp_q[$];
  int          mode = 0;
  bit          mon_en = 0;
  bit          ch1_off = 0;
  int          post_off = 0;
  int          deliv[N];
  int          duty = 100;
  int          mptr = 0;
  logic [31:0] exp_cnt = 0;
  logic [N-1:0] rd_s, gr_s;
  logic        oe_s;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic void drive_ch();
    for (int c = 0; c < N; c++) begin
      ch_empty[c] = (ch_q[c].size() == 0);
      ch_data[32*c +: 32] = (ch_q[c].size() > 0) ? ch_q[c][0] : 32'd0;
    end
  endfunction

  function automatic bit eligible();
    for (int c = 0; c < N; c++)
      if (ch_en[c] && ch_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void flush_all();
    for (int c = 0; c < N; c++) begin
      ch_q[c].delete();
      exp_ch[c].delete();
      deliv[c] = 0;
    end
    exp_q.delete();
  endfunction

  // One clock: sample at negedge, apply channel pops and new inputs after posedge
  task automatic step();
    @(negedge clk);
    rd_s = ch_read;
    oe_s = out_empty;
    gr_s = grant;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++)
      if (rd_s[c] && ch_q[c].size() > 0) void'(ch_q[c].pop_front());
    drive_ch();
    out_read = ($urandom_range(0, 99) < duty);
  endtask

  // Fill channels and predict the forwarded order from round-robin rules
  task automatic load_rr(input logic [N-1:0] en,
                         input int n0, input int n1,
                         input int n2, input int n3);
    wq_t tmp[N];
    int  n[N];
    int  g;
    int  take;
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    for (int c = 0; c < N; c++)
      for (int k = 0; k < n[c]; k++) begin
        logic [31:0] w;
        w = {4'(c), 28'($urandom)};
        ch_q[c].push_back(w);
        tmp[c].push_back(w);
      end
    forever begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (mptr + i) % N;
        if (g < 0 && en[c] && tmp[c].size() > 0) g = c;
      end
      if (g < 0) break;
      take = (tmp[g].size() < MB) ? tmp[g].size() : MB;
      for (int k = 0; k < take; k++) begin
        exp_q.push_back(tmp[g].pop_front());
        exp_cnt = sat_inc(exp_cnt);
      end
      mptr = (g + 1) % N;
    end
    ch_en = en;
    drive_ch();
  endtask

  task automatic wait_idle(string name, int budget);
    int stable;
    stable = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (oe_s && gr_s == '0 && !eligible()) stable++;
      else stable = 0;
      if (stable >= 3) return;
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    flush_all();
    ch_en = '0;
    drive_ch();
    mptr = 0;
    exp_cnt = 0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Monitor: invariants every cycle and scoreboard pop on each output transfer
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ch_read_onehot0", 32'($onehot0(ch_read)), 32'd1);
      chk("ch_read_legal", 32'(ch_read & (ch_empty | ~ch_en)), 32'd0);
      if (ch_read != '0)
        chk("read_needs_room", 32'(out_empty | out_read), 32'd1);
      if (!out_empty && out_read) begin
        int c;
        c = int'(out_data[31:28]);
        if (mode == 0) begin
          if (exp_q.size() == 0) chk("extra_word", out_data, 32'd0);
          else chk("stream_word", out_data, exp_q.pop_front());
        end else if (c < N) begin
          if (exp_ch[c].size() == 0) chk("extra_ch_word", out_data, 32'd0);
          else chk("chan_word", out_data, exp_ch[c].pop_front());
          deliv[c]++;
          if (ch1_off && c == 1) post_off++;
        end else begin
          chk("bad_tag", out_data, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    rst = 1'b1;
    ch_en = '0;
    out_read = 1'b0;
    flush_all();
    drive_ch();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_empty", 32'(out_empty), 32'd1);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_ch_read", 32'(ch_read), 32'd0);
    chk("reset_word_cnt", word_cnt, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    rst = 1'b0;
    step();

    // Reset in the middle of a burst
    load_rr(4'b0001, 20, 0, 0, 0);
    out_read = 1'b1;
    repeat (6) step();
    chk("rst_was_granted", 32'(gr_s != '0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_empty", 32'(out_empty), 32'd1);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_ch_read", 32'(ch_read), 32'd0);
    chk("midrst_word_cnt", word_cnt, 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Single channel, latency and in-order delivery
    mon_en = 1'b1;
    mode = 0;
    duty = 100;
    load_rr(4'b0001, 5, 0, 0, 0);
    out_read = 1'b1;
    first = -1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (!oe_s && first < 0) first = cyc;
    end
    chk("first_latency", 32'(first), 32'd2);
    wait_idle("single", 200);
    chk("single_drained", 32'(exp_q.size()), 32'd0);
    chk("single_word_cnt", word_cnt, exp_cnt);

    // Full round-robin with bursts
    load_rr(4'b1111, 40, 40, 40, 40);
    wait_idle("rr", 2000);
    chk("rr_drained", 32'(exp_q.size()), 32'd0);
    chk("rr_word_cnt", word_cnt, exp_cnt);

    // Random backpressure
    duty = 30;
    load_rr(4'b1111, $urandom_range(5, 35), $urandom_range(5, 35),
            $urandom_range(5, 35), $urandom_range(5, 35));
    wait_idle("bp", 8000);
    duty = 100;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_word_cnt", word_cnt, exp_cnt);

    // Static enable mask
    load_rr(4'b1010, 20, 20, 20, 20);
    wait_idle("mask", 2000);
    chk("mask_drained", 32'(exp_q.size()), 32'd0);
    chk("mask_word_cnt", word_cnt, exp_cnt);
    chk("mask_ch0_untouched", 32'(ch_q[0].size()), 32'd20);
    chk("mask_ch2_untouched", 32'(ch_q[2].size()), 32'd20);

    // Enable dropped mid-burst
    do_reset();
    mode = 1;
    ch1_off = 1'b0;
    post_off = 0;
    for (int c = 0; c < N; c++) begin
      int cnt;
      cnt = (c == 1) ? 30 : (c == 3) ? 10 : 5;
      for (int k = 0; k < cnt; k++) begin
        logic [31:0] w;
        w = {4'(c), 28'($urandom)};
        ch_q[c].push_back(w);
        if (c == 1 || c == 3) exp_ch[c].push_back(w);
      end
    end
    ch_en = 4'b1010;
    drive_ch();
    out_read = 1'b1;
    for (int i = 0; i < 100 && deliv[1] < 3; i++) step();
    chk("drop_ch1_started", 32'(deliv[1] >= 3), 32'd1);
    ch_en[1] = 1'b0;
    ch1_off = 1'b1;
    wait_idle("drop", 2000);
    chk("drop_post_off_le1", 32'(post_off <= 1), 32'd1);
    chk("drop_ch3_all", 32'(deliv[3]), 32'd10);
    chk("drop_ch1_kept", 32'(ch_q[1].size()), 32'(exp_ch[1].size()));
    chk("drop_word_cnt", word_cnt, 32'(deliv[1] + deliv[3]));
    chk("drop_ch0_untouched", 32'(ch_q[0].size()), 32'd5);

    // Counter saturation
    mode = 0;
    flush_all();
    ch_en = '0;
    drive_ch();
    step();
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.word_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    load_rr(4'b0001, 3, 0, 0, 0);
    wait_idle("sat", 200);
    chk("sat_drained", 32'(exp_q.size()), 32'd0);
    chk("sat_word_cnt", word_cnt, 32'hFFFF_FFFF);
    chk("sat_model", word_cnt, exp_cnt);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
